// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding and
// the bit positions of Z/N/C/V inside the ALU flag vector.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam int FLAG_W = 4;
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/mul_seq_param_if.sv
// Operand/result bundle between the ALU control FSM (master) and the
// sequential multiplier (slave).
interface mul_seq_param_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_high;
    logic [WIDTH-1:0] product_low;
    logic             Z;
    logic             N;
    logic             C;
    logic             V;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product_high, product_low, Z, N, C, V
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product_high, product_low, Z, N, C, V
    );

endinterface

// File: rtl/mul_shift_add_core.sv
// Unsigned WIDTH x WIDTH radix-2 shift-add datapath: one multiplier bit per
// step, LSB first; 'last' rises once all WIDTH bits have been consumed.
module mul_shift_add_core #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 last
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign last = (cnt_q == CNT_W'(WIDTH));
    assign acc  = acc_q;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, mcand};
            mplier_d = mplier;
            cnt_d    = '0;
        end else if (step && !last) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mul_seq_param.sv
// Sequential signed/unsigned multiplier: captures operand magnitudes on start,
// runs the shift-add core, then applies the sign and registers result + flags.
module mul_seq_param
    import mul_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    mul_seq_param_if.slave bus
);

    state_e state_q, state_d;

    logic               sign_q, sign_d;
    logic               smode_q, smode_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [FLAG_W-1:0]  flags_q, flags_d;

    logic               load;
    logic               last;
    logic               busy;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] result;

    assign load = (state_q == ST_IDLE) && bus.start;

    // The most-negative value negates to itself, which read unsigned is
    // exactly its magnitude 2^(WIDTH-1).
    always_comb begin
        mag_a = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    mul_shift_add_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (state_q == ST_CALC),
        .mcand  (mag_a),
        .mplier (mag_b),
        .acc    (acc),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_CALC;
            ST_CALC: if (last)      state_d = ST_FIX;
            ST_FIX:                 state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_CALC) || (state_q == ST_FIX);
    end

    // A zero magnitude negates to zero, so no negative zero can appear.
    always_comb begin
        result  = sign_q ? -acc : acc;
        sign_d  = sign_q;
        smode_d = smode_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        if (load) begin
            sign_d  = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            smode_d = bus.signed_mode;
        end
        if (state_q == ST_FIX) begin
            hi_d            = result[2*WIDTH-1:WIDTH];
            lo_d            = result[WIDTH-1:0];
            flags_d[FLAG_Z] = (result == '0);
            flags_d[FLAG_N] = smode_q & result[2*WIDTH-1];
            flags_d[FLAG_C] = !smode_q && (hi_d != '0);
            flags_d[FLAG_V] = smode_q ? (hi_d != {WIDTH{lo_d[WIDTH-1]}})
                                      : (hi_d != '0);
            done_d          = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q  <= 1'b0;
            smode_q <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            flags_q <= '0;
        end else begin
            sign_q  <= sign_d;
            smode_q <= smode_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            flags_q <= flags_d;
        end
    end

    assign bus.busy         = busy;
    assign bus.done         = done_q;
    assign bus.product_high = hi_q;
    assign bus.product_low  = lo_q;
    assign bus.Z            = flags_q[FLAG_Z];
    assign bus.N            = flags_q[FLAG_N];
    assign bus.C            = flags_q[FLAG_C];
    assign bus.V            = flags_q[FLAG_V];

endmodule

// File: tb/tb_mul_seq_param.sv
// Bench for mul_seq_param: a 16-bit and an 8-bit instance checked against an
// arithmetic reference model (signed/unsigned products and range-based flags).
module tb_mul_seq_param;

    logic clk = 1'b0;
    logic rst;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    mul_seq_param_if #(.WIDTH(16)) bus16 ();
    mul_seq_param_if #(.WIDTH(8))  bus8  ();

    mul_seq_param #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    mul_seq_param #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    // Reference: interpret operands as integers, multiply, then derive flags
    // from where the true product lies relative to the WIDTH-bit range.
    function automatic void ref_mul(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input bit sm, output logic [31:0] prod, output logic [3:0] flg);
        longint sa, sb, p, half, full;
        bit fits;
        half = longint'(1) << (w - 1);
        full = longint'(1) << w;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[w-1]) sa = sa - full;
        if (sm && b[w-1]) sb = sb - full;
        p    = sa * sb;
        prod = 32'(p & ((longint'(1) << (2 * w)) - 1));
        fits = sm ? (p >= -half && p < half) : (p < full);
        flg  = {p == 0, sm && (p < 0), !sm && (p >= full), !fits};
    endfunction

    task automatic drive16(input logic [15:0] a, input logic [15:0] b, input bit sm,
                           output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        @(negedge clk);
        bus16.a = a; bus16.b = b; bus16.signed_mode = sm; bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        bus16.a = 16'($urandom); bus16.b = 16'($urandom);
        bus16.signed_mode = 1'($urandom_range(0, 1));
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus16.done) begin
                lat = n;
                if (bus16.busy) busy_ok = 1'b0;
                break;
            end else if (!bus16.busy) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input bit sm, output int lat);
        lat = -1;
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.signed_mode = sm; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (bus8.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_compared++;
        if ({bus16.busy, bus16.done, bus16.Z, bus16.N, bus16.C, bus16.V} !== 6'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset16_ctrl_flags: got %b expected 000000",
                     {bus16.busy, bus16.done, bus16.Z, bus16.N, bus16.C, bus16.V});
        end
        n_compared++;
        if ({bus16.product_high, bus16.product_low} !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset16_product: got %h expected 00000000",
                     {bus16.product_high, bus16.product_low});
        end
        n_compared++;
        if ({bus8.busy, bus8.done, bus8.product_high, bus8.product_low,
             bus8.Z, bus8.N, bus8.C, bus8.V} !== 22'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset8_all: got %h expected 0",
                     {bus8.busy, bus8.done, bus8.product_high, bus8.product_low,
                      bus8.Z, bus8.N, bus8.C, bus8.V});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] ta[4], tb_[4], th[4], tl[4];
        logic [3:0]  tf[4];
        bit          tsm[4];
        int          lat;
        bit          busy_ok;
        ta  = '{16'hFFFF, 16'hFFFD, 16'h8000, 16'h0000};
        tb_ = '{16'hFFFF, 16'h0005, 16'h8000, 16'hFFFF};
        tsm = '{1'b0, 1'b1, 1'b1, 1'b1};
        th  = '{16'hFFFE, 16'hFFFF, 16'h4000, 16'h0000};
        tl  = '{16'h0001, 16'hFFF1, 16'h0000, 16'h0000};
        tf  = '{4'b0011, 4'b0100, 4'b0001, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            drive16(ta[i], tb_[i], tsm[i], lat, busy_ok);
            n_compared++;
            if (lat !== 18) begin
                n_mismatched++;
                $display("[TB] FAIL directed%0d_latency: got %0d expected 18", i, lat);
            end
            n_compared++;
            if (!busy_ok) begin
                n_mismatched++;
                $display("[TB] FAIL directed%0d_busy: got bad busy expected busy until done", i);
            end
            n_compared++;
            if ({bus16.product_high, bus16.product_low} !== {th[i], tl[i]}) begin
                n_mismatched++;
                $display("[TB] FAIL directed%0d_product: got %h expected %h", i,
                         {bus16.product_high, bus16.product_low}, {th[i], tl[i]});
            end
            n_compared++;
            if ({bus16.Z, bus16.N, bus16.C, bus16.V} !== tf[i]) begin
                n_mismatched++;
                $display("[TB] FAIL directed%0d_flags_ZNCV: got %b expected %b", i,
                         {bus16.Z, bus16.N, bus16.C, bus16.V}, tf[i]);
            end
            @(posedge clk); #1;
            n_compared++;
            if ({bus16.done, bus16.product_high, bus16.product_low} !== {1'b0, th[i], tl[i]}) begin
                n_mismatched++;
                $display("[TB] FAIL directed%0d_pulse_hold: got %h expected %h", i,
                         {bus16.done, bus16.product_high, bus16.product_low}, {1'b0, th[i], tl[i]});
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat = -1;
        int extra_done = 0;
        @(negedge clk);
        bus16.a = 16'h0003; bus16.b = 16'h0004; bus16.signed_mode = 1'b0; bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.signed_mode = 1'b1; bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        for (int n = 5; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus16.done) begin
                lat = n;
                break;
            end
        end
        n_compared++;
        if (lat !== 18) begin
            n_mismatched++;
            $display("[TB] FAIL ignore_latency: got %0d expected 18", lat);
        end
        n_compared++;
        if ({bus16.product_high, bus16.product_low, bus16.Z, bus16.N, bus16.C, bus16.V}
            !== {32'h0000_000C, 4'b0000}) begin
            n_mismatched++;
            $display("[TB] FAIL ignore_result: got %h expected %h",
                     {bus16.product_high, bus16.product_low, bus16.Z, bus16.N, bus16.C, bus16.V},
                     {32'h0000_000C, 4'b0000});
        end
        repeat (25) begin
            @(posedge clk); #1;
            if (bus16.done || bus16.busy) extra_done++;
        end
        n_compared++;
        if (extra_done !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL ignore_no_queue: got %0d active cycles expected 0", extra_done);
        end
    endtask

    task automatic test_reset_abort();
        int activity = 0;
        @(negedge clk);
        bus16.a = 16'h1234; bus16.b = 16'h0F0F; bus16.signed_mode = 1'b0; bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_compared++;
        if ({bus16.busy, bus16.done, bus16.product_high, bus16.product_low,
             bus16.Z, bus16.N, bus16.C, bus16.V} !== 38'h0) begin
            n_mismatched++;
            $display("[TB] FAIL abort_outputs: got %h expected 0",
                     {bus16.busy, bus16.done, bus16.product_high, bus16.product_low,
                      bus16.Z, bus16.N, bus16.C, bus16.V});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus16.done || bus16.busy) activity++;
        end
        n_compared++;
        if (activity !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", activity);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_p;
        logic [3:0]  exp_f;
        logic [15:0] a, b;
        bit          sm;
        int          lat;
        bit          busy_ok;
        drive16(16'h0102, 16'h0304, 1'b0, lat, busy_ok);
        for (int i = 0; i < 3; i++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            sm = 1'($urandom_range(0, 1));
            ref_mul(16, {16'h0, a}, {16'h0, b}, sm, exp_p, exp_f);
            drive16(a, b, sm, lat, busy_ok);
            n_compared++;
            if ({lat, busy_ok} !== {32'd18, 1'b1}) begin
                n_mismatched++;
                $display("[TB] FAIL b2b%0d_timing: got lat=%0d busy_ok=%0d expected lat=18 busy_ok=1",
                         i, lat, busy_ok);
            end
            n_compared++;
            if ({bus16.product_high, bus16.product_low, bus16.Z, bus16.N, bus16.C, bus16.V}
                !== {exp_p, exp_f}) begin
                n_mismatched++;
                $display("[TB] FAIL b2b%0d_result: got %h expected %h", i,
                         {bus16.product_high, bus16.product_low, bus16.Z, bus16.N, bus16.C, bus16.V},
                         {exp_p, exp_f});
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_p;
        logic [3:0]  exp_f;
        logic [15:0] a, b;
        bit          sm;
        int          lat;
        bit          busy_ok;
        for (int i = 0; i < 24; i++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            sm = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: a = 16'h0000;
                1: b = 16'h0000;
                2: a = 16'h8000;
                3: b = 16'hFFFF;
                default: ;
            endcase
            ref_mul(16, {16'h0, a}, {16'h0, b}, sm, exp_p, exp_f);
            drive16(a, b, sm, lat, busy_ok);
            n_compared++;
            if ({lat, busy_ok} !== {32'd18, 1'b1}) begin
                n_mismatched++;
                $display("[TB] FAIL rand%0d_timing: got lat=%0d busy_ok=%0d expected lat=18 busy_ok=1",
                         i, lat, busy_ok);
            end
            n_compared++;
            if ({bus16.product_high, bus16.product_low} !== exp_p) begin
                n_mismatched++;
                $display("[TB] FAIL rand%0d_product: a=%h b=%h s=%0d got %h expected %h", i, a, b, sm,
                         {bus16.product_high, bus16.product_low}, exp_p);
            end
            n_compared++;
            if ({bus16.Z, bus16.N, bus16.C, bus16.V} !== exp_f) begin
                n_mismatched++;
                $display("[TB] FAIL rand%0d_flags_ZNCV: a=%h b=%h s=%0d got %b expected %b", i, a, b, sm,
                         {bus16.Z, bus16.N, bus16.C, bus16.V}, exp_f);
            end
        end
    endtask

    task automatic test_width8();
        logic [31:0] exp_p;
        logic [3:0]  exp_f;
        logic [7:0]  a, b;
        bit          sm;
        int          lat;
        drive8(8'h80, 8'h7F, 1'b1, lat);
        n_compared++;
        if (lat !== 10) begin
            n_mismatched++;
            $display("[TB] FAIL w8_latency: got %0d expected 10", lat);
        end
        n_compared++;
        if ({bus8.product_high, bus8.product_low, bus8.Z, bus8.N, bus8.C, bus8.V}
            !== {16'hC080, 4'b0101}) begin
            n_mismatched++;
            $display("[TB] FAIL w8_min_times_max: got %h expected %h",
                     {bus8.product_high, bus8.product_low, bus8.Z, bus8.N, bus8.C, bus8.V},
                     {16'hC080, 4'b0101});
        end
        for (int i = 0; i < 10; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            sm = 1'($urandom_range(0, 1));
            ref_mul(8, {24'h0, a}, {24'h0, b}, sm, exp_p, exp_f);
            drive8(a, b, sm, lat);
            n_compared++;
            if ({lat, bus8.product_high, bus8.product_low, bus8.Z, bus8.N, bus8.C, bus8.V}
                !== {32'd10, exp_p[15:0], exp_f}) begin
                n_mismatched++;
                $display("[TB] FAIL w8_rand%0d: a=%h b=%h s=%0d got lat=%0d %h expected lat=10 %h",
                         i, a, b, sm, lat,
                         {bus8.product_high, bus8.product_low, bus8.Z, bus8.N, bus8.C, bus8.V},
                         {exp_p[15:0], exp_f});
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus16.start = 1'b0; bus16.signed_mode = 1'b0; bus16.a = '0; bus16.b = '0;
        bus8.start  = 1'b0; bus8.signed_mode  = 1'b0; bus8.a  = '0; bus8.b  = '0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
